// File: rtl/fir_coef_load_ctrl.sv
// FIR coefficient loader: syncs a start button and a coefficient strobe,
// then writes N_COEF captured values into the coefficient bank.
module fir_coef_load_ctrl #(
  parameter int N_COEF = 16,
  parameter int COEF_W = 12,
  parameter int ADDR_W = 4
) (
  input  logic              clk_100MHz_i,
  input  logic              rst_i,
  input  logic              pulsador_carga_coef_i,
  input  logic              cambio_coef_i,
  input  logic [COEF_W-1:0] coef_in,
  output logic              coef_we_o,
  output logic [ADDR_W-1:0] coef_addr_o,
  output logic [COEF_W-1:0] coef_data_o,
  output logic              fir_clr_o,
  output logic              fir_en_o,
  output logic              loading_o,
  output logic              coef_valid_o,
  output logic              load_done_o
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_COEF,
    WRITE,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_COEF - 1);

  state_t state, next;

  logic [2:0]        start_sync;
  logic [2:0]        strb_sync;
  logic              start_edge;
  logic              strb_edge;
  logic [ADDR_W-1:0] cnt;
  logic [COEF_W-1:0] data_q;
  logic              valid_q;
  logic              clr_q;
  logic              cnt_clr;
  logic              cnt_inc;
  logic              capture;

  // Bit 0/1 form the synchroniser, bit 2 holds the previous level.
  always_ff @(posedge clk_100MHz_i or posedge rst_i) begin
    if (rst_i) begin
      start_sync <= '0;
      strb_sync  <= '0;
    end else begin
      start_sync <= {start_sync[1:0], pulsador_carga_coef_i};
      strb_sync  <= {strb_sync[1:0], cambio_coef_i};
    end
  end

  assign start_edge = start_sync[1] & ~start_sync[2];
  assign strb_edge  = strb_sync[1] & ~strb_sync[2];

  always_ff @(posedge clk_100MHz_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= next;
  end

  // A start edge overrides everything, including a same-cycle strobe.
  always_comb begin
    next    = state;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    capture = 1'b0;
    if (start_edge) begin
      next    = WAIT_COEF;
      cnt_clr = 1'b1;
    end else begin
      unique case (state)
        IDLE: next = IDLE;
        WAIT_COEF: begin
          if (strb_edge) begin
            capture = 1'b1;
            next    = WRITE;
          end
        end
        WRITE: begin
          if (cnt == LAST) begin
            next = DONE;
          end else begin
            cnt_inc = 1'b1;
            next    = WAIT_COEF;
          end
        end
        DONE:    next = IDLE;
        default: next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_100MHz_i or posedge rst_i) begin
    if (rst_i) begin
      cnt     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      clr_q <= start_edge;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;
      if (capture) data_q <= coef_in;
      if (start_edge)        valid_q <= 1'b0;
      else if (next == DONE) valid_q <= 1'b1;
    end
  end

  assign coef_we_o    = (state == WRITE);
  assign coef_addr_o  = cnt;
  assign coef_data_o  = data_q;
  assign fir_clr_o    = clr_q;
  assign loading_o    = (state == WAIT_COEF) || (state == WRITE);
  assign coef_valid_o = valid_q;
  assign fir_en_o     = valid_q && (state == IDLE);
  assign load_done_o  = (state == DONE);

endmodule

// File: tb/tb_fir_coef_load_ctrl.sv
// Directed bench for fir_coef_load_ctrl: load, latency, restart,
// collision, reset-abort and idle-strobe scenarios.
module tb_fir_coef_load_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        puls;
  logic        strb;
  logic [11:0] cin;
  logic        we;
  logic [3:0]  addr;
  logic [11:0] dout;
  logic        clr;
  logic        en;
  logic        loading;
  logic        valid;
  logic        done;

  int checks = 0;
  int failures = 0;

  int wr_n = 0;
  int done_n = 0;
  int clr_n = 0;
  logic [3:0]  wr_addr [256];
  logic [11:0] wr_data [256];

  fir_coef_load_ctrl dut (
    .clk_100MHz_i          (clk),
    .rst_i                 (rst),
    .pulsador_carga_coef_i (puls),
    .cambio_coef_i         (strb),
    .coef_in               (cin),
    .coef_we_o             (we),
    .coef_addr_o           (addr),
    .coef_data_o           (dout),
    .fir_clr_o             (clr),
    .fir_en_o              (en),
    .loading_o             (loading),
    .coef_valid_o          (valid),
    .load_done_o           (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (we) begin
        if (wr_n < 256) begin
          wr_addr[wr_n] = addr;
          wr_data[wr_n] = dout;
        end
        wr_n++;
      end
      if (done) done_n++;
      if (clr) clr_n++;
    end
  end

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic press_start();
    @(negedge clk);
    puls = 1'b1;
    repeat (6) @(negedge clk);
    puls = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_coef(input logic [11:0] v, input int gap);
    @(negedge clk);
    cin  = v;
    strb = 1'b1;
    repeat (8) @(negedge clk);
    strb = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    puls = 1'b0;
    strb = 1'b0;
    cin  = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({we, addr, dout, clr, en, loading, valid, done} !== 23'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0",
               {we, addr, dout, clr, en, loading, valid, done});
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (loading !== 1'b0 || clr_n != 0) begin
      failures++;
      $display("FAIL reset_release loading=%b clr_n=%0d want 0/0",
               loading, clr_n);
    end
  endtask

  task automatic test_idle_strobe();
    int w0;
    w0 = wr_n;
    send_coef(12'h5A5, 6);
    settle();
    checks++;
    if (wr_n != w0 || loading !== 1'b0) begin
      failures++;
      $display("FAIL idle_strobe writes=%0d loading=%b want 0/0",
               wr_n - w0, loading);
    end
  endtask

  task automatic test_full_load();
    int vals [16] = '{-99, 65, 136, 33, -156, -86, 376, 854,
                      854, 376, -86, -156, 33, 136, 65, -99};
    logic [11:0] exp;
    int w0;
    int d0;
    int c0;
    w0 = wr_n;
    d0 = done_n;
    c0 = clr_n;
    press_start();
    checks++;
    if (clr_n != c0 + 1 || loading !== 1'b1) begin
      failures++;
      $display("FAIL full_start clr_pulses=%0d loading=%b want 1/1",
               clr_n - c0, loading);
    end
    for (int i = 0; i < 16; i++) send_coef(12'(vals[i]), 860);
    settle();
    checks++;
    if (wr_n != w0 + 16) begin
      failures++;
      $display("FAIL full_count got=%0d want=16", wr_n - w0);
    end
    for (int i = 0; i < 16; i++) begin
      exp = 12'(vals[i]);
      checks++;
      if (wr_addr[w0+i] !== 4'(i) || wr_data[w0+i] !== exp) begin
        failures++;
        $display("FAIL full_write%0d got=%h/%h want=%h/%h", i,
                 wr_addr[w0+i], wr_data[w0+i], 4'(i), exp);
      end
    end
    checks++;
    if (wr_data[w0] !== 12'hF9D) begin
      failures++;
      $display("FAIL full_neg99 got=%h want=F9D", wr_data[w0]);
    end
    checks++;
    if (done_n != d0 + 1 || valid !== 1'b1 || en !== 1'b1 ||
        loading !== 1'b0) begin
      failures++;
      $display("FAIL full_end done=%0d valid=%b en=%b loading=%b want 1/1/1/0",
               done_n - d0, valid, en, loading);
    end
  endtask

  task automatic test_restart();
    int c0;
    int w0;
    c0 = clr_n;
    press_start();
    checks++;
    if (clr_n != c0 + 1 || valid !== 1'b0 || en !== 1'b0) begin
      failures++;
      $display("FAIL restart_from_idle clr=%0d valid=%b en=%b want 1/0/0",
               clr_n - c0, valid, en);
    end
    w0 = wr_n;
    for (int i = 0; i < 5; i++) send_coef(12'(i + 1), 6);
    checks++;
    if (wr_n != w0 + 5 || wr_addr[w0+4] !== 4'd4) begin
      failures++;
      $display("FAIL restart_five writes=%0d last_addr=%h want 5/4",
               wr_n - w0, wr_addr[w0+4]);
    end
    c0 = clr_n;
    press_start();
    checks++;
    if (clr_n != c0 + 1 || valid !== 1'b0 || loading !== 1'b1) begin
      failures++;
      $display("FAIL restart_pulse clr=%0d valid=%b loading=%b want 1/0/1",
               clr_n - c0, valid, loading);
    end
    w0 = wr_n;
    send_coef(12'h123, 6);
    checks++;
    if (wr_n != w0 + 1 || wr_addr[w0] !== 4'd0 || wr_data[w0] !== 12'h123) begin
      failures++;
      $display("FAIL restart_addr0 n=%0d got=%h/%h want 1/0/123",
               wr_n - w0, wr_addr[w0], wr_data[w0]);
    end
  endtask

  task automatic test_latency();
    int w0;
    press_start();
    w0 = wr_n;
    @(negedge clk);
    cin  = 12'h7FF;
    strb = 1'b1;
    settle();
    settle();
    checks++;
    if (we !== 1'b0) begin
      failures++;
      $display("FAIL latency_early we=%b want 0 after 2nd edge", we);
    end
    settle();
    checks++;
    if (we !== 1'b1 || addr !== 4'd0 || dout !== 12'h7FF) begin
      failures++;
      $display("FAIL latency_3rd we/addr/data=%b/%h/%h want 1/0/7FF",
               we, addr, dout);
    end
    settle();
    checks++;
    if (we !== 1'b0) begin
      failures++;
      $display("FAIL latency_single we=%b want 0", we);
    end
    repeat (100) @(negedge clk);
    strb = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (wr_n != w0 + 1) begin
      failures++;
      $display("FAIL latency_hold writes=%0d want=1", wr_n - w0);
    end
  endtask

  task automatic test_collision();
    int w0;
    int c0;
    press_start();
    send_coef(12'h0AA, 6);
    send_coef(12'h0BB, 6);
    w0 = wr_n;
    c0 = clr_n;
    @(negedge clk);
    cin  = 12'h0CC;
    puls = 1'b1;
    strb = 1'b1;
    repeat (8) @(negedge clk);
    puls = 1'b0;
    strb = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (wr_n != w0 || clr_n != c0 + 1) begin
      failures++;
      $display("FAIL collision writes=%0d clr=%0d want 0/1",
               wr_n - w0, clr_n - c0);
    end
    send_coef(12'h0DD, 6);
    checks++;
    if (wr_n != w0 + 1 || wr_addr[w0] !== 4'd0 || wr_data[w0] !== 12'h0DD) begin
      failures++;
      $display("FAIL collision_next n=%0d got=%h/%h want 1/0/0DD",
               wr_n - w0, wr_addr[w0], wr_data[w0]);
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    int budget;
    press_start();
    for (int i = 0; i < 7; i++) send_coef(12'(i + 16), 6);
    @(negedge clk);
    cin  = 12'h321;
    strb = 1'b1;
    budget = 0;
    settle();
    while (we !== 1'b1 && budget < 10) begin
      settle();
      budget++;
    end
    checks++;
    if (we !== 1'b1 || addr !== 4'd7) begin
      failures++;
      $display("FAIL midreset_8th we=%b addr=%h want 1/7", we, addr);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({we, addr, dout, clr, en, loading, valid, done} !== 23'd0) begin
      failures++;
      $display("FAIL midreset_async got=%h want=0",
               {we, addr, dout, clr, en, loading, valid, done});
    end
    strb = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    w0 = wr_n;
    for (int i = 0; i < 3; i++) send_coef(12'h111, 6);
    checks++;
    if (wr_n != w0 || loading !== 1'b0 || valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_after writes=%0d loading=%b valid=%b want 0/0/0",
               wr_n - w0, loading, valid);
    end
  endtask

  initial begin
    test_reset();
    test_idle_strobe();
    test_full_load();
    test_restart();
    test_latency();
    test_collision();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
